// File: rtl/alu_multicycle.sv
// alu_multicycle
//   EX-stage ALU with a registered result and a valid/ready handshake.
//   Logic, arithmetic, compare and shift ops finish in one cycle.
//   MULT/MULTU/DIV/DIVU run iteratively, one shift-add or restoring-subtract
//   step per clock, and report the high product half or the remainder on hi.
//   The hazard unit stalls the pipe while in_ready is low.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   in_valid   in   1      op1/op2/alu_conf are valid this cycle
//   in_ready   out  1      block can accept an op (high only when idle)
//   op1        in   WIDTH  operand A (rs)
//   op2        in   WIDTH  operand B (rt/imm); shift amount is op2[SHW-1:0]
//   alu_conf   in   4      operation select
//   out_valid  out  1      one-cycle pulse: result/hi/zero hold a new value
//   result     out  WIDTH  main result / product low half / quotient
//   hi         out  WIDTH  product high half / remainder; 0 for other ops
//   zero       out  1      result == 0, registered together with result

module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_conf,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [SHW-1:0]     cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opb;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic               op_is_div;

  logic               accept;
  logic               is_mul_op;
  logic               is_div_op;
  logic               signed_op;
  logic               op1_neg;
  logic               op2_neg;
  logic [WIDTH-1:0]   op1_abs;
  logic [WIDTH-1:0]   op2_abs;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   single_res;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic               rem_fits;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_res;
  logic [WIDTH-1:0]   fix_hi;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign is_mul_op = (alu_conf == OP_MULT) || (alu_conf == OP_MULTU);
  assign is_div_op = (alu_conf == OP_DIV)  || (alu_conf == OP_DIVU);
  assign signed_op = (alu_conf == OP_MULT) || (alu_conf == OP_DIV);
  assign shamt     = op2[SHW-1:0];

  // The iterative units work on magnitudes; the signs are remembered
  // separately and applied once in FIX.
  assign op1_neg = signed_op & op1[WIDTH-1];
  assign op2_neg = signed_op & op2[WIDTH-1];
  assign op1_abs = op1_neg ? -op1 : op1;
  assign op2_abs = op2_neg ? -op2 : op2;

  // Single-cycle datapath. Unused and multi-cycle codes fall to zero here;
  // multi-cycle codes never load this value anyway.
  always_comb begin
    single_res = '0;
    case (alu_conf)
      OP_AND:  single_res = op1 & op2;
      OP_OR:   single_res = op1 | op2;
      OP_XOR:  single_res = op1 ^ op2;
      OP_NOR:  single_res = ~(op1 | op2);
      OP_ADD:  single_res = op1 + op2;
      OP_SUB:  single_res = op1 - op2;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      OP_SLL:  single_res = op1 << shamt;
      OP_SRL:  single_res = op1 >> shamt;
      OP_SRA:  single_res = $signed(op1) >>> shamt;
      default: single_res = '0;
    endcase
  end

  // One iteration step of each unit. The multiplier keeps {acc_hi, acc_lo}
  // as a right-shifting product with the multiplier in acc_lo; the divider
  // keeps the partial remainder in acc_hi and shifts the dividend out of
  // acc_lo while the quotient bits shift in behind it.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    rem_shift = {acc_hi, acc_lo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opb};
    rem_fits  = (rem_shift >= {1'b0, opb});
  end

  // Sign correction applied in FIX. Divide by zero forces an all-ones
  // quotient; the remainder path already reproduces op1 in that case.
  // MIN / -1 needs no special case: |MIN| / 1 with matching signs gives MIN.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_res ? -prod : prod;
    fix_res  = prod_fix[WIDTH-1:0];
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    if (op_is_div) begin
      fix_res = div_zero ? {WIDTH{1'b1}} : (neg_res ? -acc_lo : acc_lo);
      fix_hi  = neg_rem ? -acc_hi : acc_hi;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: multi-cycle ops run WIDTH iterations, then one FIX
  // cycle, then return to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_mul_op) begin
          state_next = MUL;
        end else if (accept && is_div_op) begin
          state_next = DIV;
        end
      end
      MUL, DIV: begin
        if (cnt == LAST_ITER) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output registers. Single-cycle ops load result/hi/zero at
  // the accept edge; multi-cycle ops latch magnitudes and signs there, step
  // once per edge in MUL/DIV, and load the outputs at the FIX edge. The
  // counter wraps back to zero on its last step because WIDTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      hi        <= '0;
      zero      <= 1'b1;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opb       <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
      op_is_div <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul_op || is_div_op) begin
              acc_hi    <= '0;
              acc_lo    <= op1_abs;
              opb       <= op2_abs;
              neg_res   <= op1_neg ^ op2_neg;
              neg_rem   <= op1_neg;
              div_zero  <= (op2 == '0);
              op_is_div <= is_div_op;
              cnt       <= '0;
            end else begin
              result    <= single_res;
              hi        <= '0;
              zero      <= (single_res == '0);
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
        end
        DIV: begin
          if (rem_fits) begin
            acc_hi <= rem_diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= rem_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          result    <= fix_res;
          hi        <= fix_hi;
          zero      <= (fix_res == '0);
          out_valid <= 1'b1;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle
//   Directed test of alu_multicycle at WIDTH=32 and WIDTH=8 with
//   hand-computed expected values.

module tb_alu_multicycle;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  alu_conf;
  logic        out_valid;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  op1_8;
  logic [7:0]  op2_8;
  logic [3:0]  alu_conf8;
  logic        out_valid8;
  logic [7:0]  result8;
  logic [7:0]  hi8;
  logic        zero8;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .alu_conf  (alu_conf),
    .out_valid (out_valid),
    .result    (result),
    .hi        (hi),
    .zero      (zero)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .op1       (op1_8),
    .op2       (op2_8),
    .alu_conf  (alu_conf8),
    .out_valid (out_valid8),
    .result    (result8),
    .hi        (hi8),
    .zero      (zero8)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one single-cycle op for exactly one edge.
  task automatic do_single(input logic [3:0] conf, input logic [31:0] a, input logic [31:0] b);
    alu_conf = conf;
    op1      = a;
    op2      = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Issue a multi-cycle op, then keep presenting a different op while busy.
  // Returns the number of edges from accept to out_valid (0 on timeout) and
  // whether in_ready stayed low the whole time.
  task automatic run_multi(input logic [3:0] conf, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic busy_ok);
    lat      = 0;
    busy_ok  = 1'b1;
    alu_conf = conf;
    op1      = a;
    op2      = b;
    in_valid = 1'b1;
    tick();
    alu_conf = OP_ADD;
    op1      = 32'h0000_1234;
    op2      = 32'h0000_0001;
    for (int i = 1; i <= 100; i++) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      tick();
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    alu_conf  = OP_AND;
    op1       = '0;
    op2       = '0;
    in_valid8 = 1'b0;
    alu_conf8 = OP_AND;
    op1_8     = '0;
    op2_8     = '0;
    tick();
    tick();
    tests_run++;
    if ({out_valid, in_ready, zero} !== 3'b011) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got {ov,rdy,z}=%b expected 011", {out_valid, in_ready, zero});
    end
    tests_run++;
    if ({result, hi} !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_result: got %h_%h expected 0", hi, result);
    end
    tests_run++;
    if ({out_valid8, in_ready8, zero8, result8, hi8} !== {3'b011, 16'h0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_w8: got ov=%b rdy=%b z=%b r=%h h=%h expected 0 1 1 00 00",
               out_valid8, in_ready8, zero8, result8, hi8);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    alu_conf = OP_ADD;
    op1      = 32'd7;
    op2      = 32'd5;
    in_valid = 1'b1;
    tick();
    tests_run++;
    if ({out_valid, zero, result} !== {2'b10, 32'd12}) begin
      tests_failed++;
      $display("[TB] FAIL add_7_5: got ov=%b z=%b r=%h expected 1 0 0000000c", out_valid, zero, result);
    end
    alu_conf = OP_SUB;
    op1      = 32'd5;
    op2      = 32'd7;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, zero, result} !== {2'b10, 32'hFFFF_FFFE}) begin
      tests_failed++;
      $display("[TB] FAIL sub_5_7: got ov=%b z=%b r=%h expected 1 0 fffffffe", out_valid, zero, result);
    end
    tick();
    tests_run++;
    if ({out_valid, result} !== {1'b0, 32'hFFFF_FFFE}) begin
      tests_failed++;
      $display("[TB] FAIL hold_after_sub: got ov=%b r=%h expected 0 fffffffe", out_valid, result);
    end
  endtask

  task automatic test_compare_shift();
    do_single(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    tests_run++;
    if (result !== 32'd1) begin
      tests_failed++;
      $display("[TB] FAIL slt: got %h expected 00000001", result);
    end
    do_single(OP_SLTU, 32'hFFFF_FFFF, 32'd1);
    tests_run++;
    if ({zero, result} !== {1'b1, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL sltu: got z=%b r=%h expected 1 00000000", zero, result);
    end
    do_single(OP_SRA, 32'h8000_0000, 32'd4);
    tests_run++;
    if (result !== 32'hF800_0000) begin
      tests_failed++;
      $display("[TB] FAIL sra: got %h expected f8000000", result);
    end
    do_single(OP_SRL, 32'h8000_0000, 32'd4);
    tests_run++;
    if (result !== 32'h0800_0000) begin
      tests_failed++;
      $display("[TB] FAIL srl: got %h expected 08000000", result);
    end
    do_single(OP_SLL, 32'd1, 32'h0000_0023);
    tests_run++;
    if (result !== 32'd8) begin
      tests_failed++;
      $display("[TB] FAIL sll_shamt_mask: got %h expected 00000008", result);
    end
    do_single(OP_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    tests_run++;
    if (result !== 32'h5555_5555) begin
      tests_failed++;
      $display("[TB] FAIL xor: got %h expected 55555555", result);
    end
    do_single(OP_NOR, 32'h0000_00F0, 32'h0000_000F);
    tests_run++;
    if (result !== 32'hFFFF_FF00) begin
      tests_failed++;
      $display("[TB] FAIL nor: got %h expected ffffff00", result);
    end
    do_single(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
    tests_run++;
    if (result !== 32'h00F0_1200) begin
      tests_failed++;
      $display("[TB] FAIL and: got %h expected 00f01200", result);
    end
    do_single(OP_OR, 32'hF000_0001, 32'h0000_0010);
    tests_run++;
    if (result !== 32'hF000_0011) begin
      tests_failed++;
      $display("[TB] FAIL or: got %h expected f0000011", result);
    end
    do_single(4'b1111, 32'h1234_5678, 32'h1);
    tests_run++;
    if ({out_valid, zero, result} !== {2'b11, 32'd0}) begin
      tests_failed++;
      $display("[TB] FAIL undefined_op: got ov=%b z=%b r=%h expected 1 1 00000000", out_valid, zero, result);
    end
  endtask

  task automatic test_mult();
    int   lat;
    logic busy_ok;
    run_multi(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, busy_ok);
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("[TB] FAIL mult_latency: got %0d expected 33", lat);
    end
    tests_run++;
    if (busy_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mult_ready_low: got in_ready high while busy expected low");
    end
    tests_run++;
    if ({hi, result} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      tests_failed++;
      $display("[TB] FAIL mult_neg3_5: got %h_%h expected ffffffff_fffffff1", hi, result);
    end
    tick();
    tests_run++;
    if ({out_valid, result} !== {1'b0, 32'hFFFF_FFF1}) begin
      tests_failed++;
      $display("[TB] FAIL mult_ignored_inflight: got ov=%b r=%h expected 0 fffffff1", out_valid, result);
    end
    run_multi(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy_ok);
    tests_run++;
    if ({hi, result} !== 64'hFFFF_FFFE_0000_0001) begin
      tests_failed++;
      $display("[TB] FAIL multu_max: got %h_%h expected fffffffe_00000001", hi, result);
    end
    do_single(OP_ADD, 32'd1, 32'd1);
    tests_run++;
    if ({hi, result} !== 64'h0000_0000_0000_0002) begin
      tests_failed++;
      $display("[TB] FAIL hi_cleared_by_add: got %h_%h expected 00000000_00000002", hi, result);
    end
  endtask

  task automatic test_div();
    int   lat;
    logic busy_ok;
    run_multi(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, busy_ok);
    tests_run++;
    if ({lat, hi, result} !== {32'd33, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      tests_failed++;
      $display("[TB] FAIL div_neg7_2: got lat=%0d %h_%h expected 33 ffffffff_fffffffd", lat, hi, result);
    end
    run_multi(OP_DIVU, 32'd7, 32'd0, lat, busy_ok);
    tests_run++;
    if ({lat, hi, result} !== {32'd33, 32'd7, 32'hFFFF_FFFF}) begin
      tests_failed++;
      $display("[TB] FAIL divu_by_zero: got lat=%0d %h_%h expected 33 00000007_ffffffff", lat, hi, result);
    end
    run_multi(OP_DIV, 32'hFFFF_FFF9, 32'd0, lat, busy_ok);
    tests_run++;
    if ({hi, result} !== 64'hFFFF_FFF9_FFFF_FFFF) begin
      tests_failed++;
      $display("[TB] FAIL div_neg_by_zero: got %h_%h expected fffffff9_ffffffff", hi, result);
    end
    run_multi(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_ok);
    tests_run++;
    if ({zero, hi, result} !== {1'b0, 32'd0, 32'h8000_0000}) begin
      tests_failed++;
      $display("[TB] FAIL div_min_neg1: got z=%b %h_%h expected 0 00000000_80000000", zero, hi, result);
    end
    run_multi(OP_DIVU, 32'd100, 32'd7, lat, busy_ok);
    tests_run++;
    if ({busy_ok, hi, result} !== {1'b1, 32'd2, 32'd14}) begin
      tests_failed++;
      $display("[TB] FAIL divu_100_7: got rdy_ok=%b %h_%h expected 1 00000002_0000000e", busy_ok, hi, result);
    end
  endtask

  task automatic test_reset_midop();
    logic late_valid;
    late_valid = 1'b0;
    alu_conf   = OP_DIV;
    op1        = 32'd1000;
    op2        = 32'd3;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if ({in_ready, out_valid, zero, result, hi} !== {3'b101, 64'h0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_midop: got rdy=%b ov=%b z=%b r=%h h=%h expected 1 0 1 0 0",
               in_ready, out_valid, zero, result, hi);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid !== 1'b0) late_valid = 1'b1;
    end
    tests_run++;
    if (late_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL no_late_valid: got out_valid pulse after reset expected none");
    end
  endtask

  task automatic test_width8();
    int lat;
    lat       = 0;
    alu_conf8 = OP_MULT;
    op1_8     = 8'hFD;
    op2_8     = 8'h05;
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_valid8 === 1'b1) begin
        lat = i;
        break;
      end
    end
    tests_run++;
    if (lat !== 9) begin
      tests_failed++;
      $display("[TB] FAIL w8_mult_latency: got %0d expected 9", lat);
    end
    tests_run++;
    if ({hi8, result8} !== 16'hFFF1) begin
      tests_failed++;
      $display("[TB] FAIL w8_mult_neg3_5: got %h_%h expected ff_f1", hi8, result8);
    end
    lat       = 0;
    alu_conf8 = OP_DIVU;
    op1_8     = 8'hC8;
    op2_8     = 8'h07;
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_valid8 === 1'b1) begin
        lat = i;
        break;
      end
    end
    tests_run++;
    if ({lat, hi8, result8} !== {32'd9, 8'h04, 8'h1C}) begin
      tests_failed++;
      $display("[TB] FAIL w8_divu_200_7: got lat=%0d %h_%h expected 9 04_1c", lat, hi8, result8);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_back_to_back();
    test_compare_shift();
    test_mult();
    test_div();
    test_reset_midop();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
